// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

    localparam int LANES = 8;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus: valid/ready request channel plus a separate load-response channel.
interface mem_access_stage_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();
    import mem_stage_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [LANES-1:0]  req_wstrb;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_addr, req_we, req_wstrb, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wstrb, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half/word/double from a 64-bit line and extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  lane,
    input  mem_size_e   size,
    input  logic        zero_ext,
    output logic [63:0] wb_data
);
    logic [63:0] shifted;

    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        unique case (size)
            SZ_B:    wb_data = {{56{shifted[7]  & ~zero_ext}}, shifted[7:0]};
            SZ_H:    wb_data = {{48{shifted[15] & ~zero_ext}}, shifted[15:0]};
            SZ_W:    wb_data = {{32{shifted[31] & ~zero_ext}}, shifted[31:0]};
            default: wb_data = shifted;
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes ALU results through, runs loads/stores over the memory bus,
// and stalls the execute stage while a transaction is outstanding.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_aluresult,
    input  logic [5:0]        ex_dest_reg,
    input  logic              ex_mem_active,
    input  logic              ex_load,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    output logic              mem_stall,
    mem_access_stage_if.master bus,
    output logic              wb_valid,
    output logic              wb_wen,
    output logic [5:0]        wb_dest_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign
);
    mem_state_e       state, state_nx;
    mem_size_e        ex_sz;
    logic             ex_misalign;
    logic [LANES-1:0] lane_mask;
    logic [LANES-1:0] st_wstrb;
    logic [63:0]      st_wdata;
    logic [63:0]      ld_data;

    logic [5:0]       cap_dest;
    logic [2:0]       cap_lane;
    mem_size_e        cap_size;
    logic             cap_unsigned;
    logic             cap_load;

    assign ex_sz     = mem_size_e'(ex_size);
    assign mem_stall = (state != IDLE);

    always_comb begin
        unique case (ex_sz)
            SZ_B:    begin ex_misalign = 1'b0;                 lane_mask = 8'h01; st_wdata = {8{ex_store_data[7:0]}};  end
            SZ_H:    begin ex_misalign = ex_aluresult[0];      lane_mask = 8'h03; st_wdata = {4{ex_store_data[15:0]}}; end
            SZ_W:    begin ex_misalign = |ex_aluresult[1:0];   lane_mask = 8'h0F; st_wdata = {2{ex_store_data[31:0]}}; end
            default: begin ex_misalign = |ex_aluresult[2:0];   lane_mask = 8'hFF; st_wdata = ex_store_data;            end
        endcase
        st_wstrb = lane_mask << ex_aluresult[2:0];
    end

    load_align u_load_align (
        .rdata    (bus.resp_rdata),
        .lane     (cap_lane),
        .size     (cap_size),
        .zero_ext (cap_unsigned),
        .wb_data  (ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: next-state defaults to the current state first so no latch is inferred.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (ex_valid && ex_mem_active && !ex_misalign) state_nx = REQ;
            REQ:     if (bus.req_ready) state_nx = cap_load ? WAIT : IDLE;
            WAIT:    if (bus.resp_valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.req_valid <= 1'b0;
            bus.req_addr  <= '0;
            bus.req_we    <= 1'b0;
            bus.req_wstrb <= '0;
            bus.req_wdata <= '0;
            wb_valid      <= 1'b0;
            wb_wen        <= 1'b0;
            wb_dest_reg   <= '0;
            wb_data       <= '0;
            misalign      <= 1'b0;
            cap_dest      <= '0;
            cap_lane      <= '0;
            cap_size      <= SZ_B;
            cap_unsigned  <= 1'b0;
            cap_load      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
            misalign <= 1'b0;
            unique case (state)
                IDLE: if (ex_valid) begin
                    cap_dest     <= ex_dest_reg;
                    cap_lane     <= ex_aluresult[2:0];
                    cap_size     <= ex_sz;
                    cap_unsigned <= ex_unsigned;
                    cap_load     <= ex_load;
                    if (!ex_mem_active) begin
                        wb_valid    <= 1'b1;
                        wb_wen      <= (ex_dest_reg != 6'd0);
                        wb_dest_reg <= ex_dest_reg;
                        wb_data     <= ex_aluresult;
                    end else if (ex_misalign) begin
                        wb_valid    <= 1'b1;
                        wb_dest_reg <= ex_dest_reg;
                        wb_data     <= '0;
                        misalign    <= 1'b1;
                    end else begin
                        bus.req_valid <= 1'b1;
                        bus.req_addr  <= {ex_aluresult[ADDR_W-1:3], 3'b000};
                        bus.req_we    <= !ex_load;
                        bus.req_wstrb <= ex_load ? '0 : st_wstrb;
                        bus.req_wdata <= ex_load ? '0 : st_wdata;
                    end
                end
                REQ: if (bus.req_ready) begin
                    bus.req_valid <= 1'b0;
                    if (!cap_load) begin
                        wb_valid    <= 1'b1;
                        wb_dest_reg <= cap_dest;
                        wb_data     <= '0;
                    end
                end
                WAIT: if (bus.resp_valid) begin
                    wb_valid    <= 1'b1;
                    wb_wen      <= (cap_dest != 6'd0);
                    wb_dest_reg <= cap_dest;
                    wb_data     <= ld_data;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; the bench plays the data memory.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0;
    logic [63:0] ex_aluresult = '0;
    logic [5:0]  ex_dest_reg = '0;
    logic        ex_mem_active = 1'b0;
    logic        ex_load = 1'b0;
    logic [63:0] ex_store_data = '0;
    logic [1:0]  ex_size = '0;
    logic        ex_unsigned = 1'b0;
    logic        mem_stall;
    logic        wb_valid;
    logic        wb_wen;
    logic [5:0]  wb_dest_reg;
    logic [63:0] wb_data;
    logic        misalign;

    int checks = 0;
    int failures = 0;

    mem_access_stage_if bus ();

    mem_access_stage dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_aluresult  (ex_aluresult),
        .ex_dest_reg   (ex_dest_reg),
        .ex_mem_active (ex_mem_active),
        .ex_load       (ex_load),
        .ex_store_data (ex_store_data),
        .ex_size       (ex_size),
        .ex_unsigned   (ex_unsigned),
        .mem_stall     (mem_stall),
        .bus           (bus),
        .wb_valid      (wb_valid),
        .wb_wen        (wb_wen),
        .wb_dest_reg   (wb_dest_reg),
        .wb_data       (wb_data),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Presents one instruction for exactly one capture edge, then samples 1 time unit later.
    task automatic send(input logic mem, input logic ld, input logic [63:0] addr, input logic [1:0] size,
                        input logic uns, input logic [5:0] dest, input logic [63:0] sdata);
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_active = mem; ex_load = ld; ex_aluresult = addr;
        ex_size = size; ex_unsigned = uns; ex_dest_reg = dest; ex_store_data = sdata;
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] size, input logic uns,
                           input logic [5:0] dest, input logic [63:0] rdata, input logic [63:0] exp_addr,
                           input logic [63:0] exp_data, input logic exp_wen);
        send(1'b1, 1'b1, addr, size, uns, dest, 64'h0);
        check({tag, "_req_valid"}, bus.req_valid, 1);
        check({tag, "_req_addr"}, bus.req_addr, exp_addr);
        check({tag, "_req_we"}, bus.req_we, 0);
        check({tag, "_stall_req"}, mem_stall, 1);
        bus.req_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_ready = 1'b0;
        check({tag, "_req_dropped"}, bus.req_valid, 0);
        check({tag, "_stall_wait"}, mem_stall, 1);
        check({tag, "_no_early_wb"}, wb_valid, 0);
        bus.resp_valid = 1'b1; bus.resp_rdata = rdata;
        @(posedge clk); #1;
        bus.resp_valid = 1'b0;
        check({tag, "_wb_valid"}, wb_valid, 1);
        check({tag, "_wb_data"}, wb_data, exp_data);
        check({tag, "_wb_wen"}, wb_wen, exp_wen);
        check({tag, "_wb_dest"}, wb_dest_reg, dest);
        check({tag, "_stall_done"}, mem_stall, 0);
        @(posedge clk); #1;
        check({tag, "_wb_pulse"}, wb_valid, 0);
    endtask

    task automatic do_store(input string tag, input logic [63:0] addr, input logic [1:0] size,
                            input logic [63:0] sdata, input logic [63:0] exp_addr, input logic [7:0] exp_strb,
                            input logic [63:0] exp_wdata, input int ready_delay);
        send(1'b1, 1'b0, addr, size, 1'b0, 6'd3, sdata);
        check({tag, "_req_valid"}, bus.req_valid, 1);
        check({tag, "_req_addr"}, bus.req_addr, exp_addr);
        check({tag, "_req_we"}, bus.req_we, 1);
        check({tag, "_wstrb"}, bus.req_wstrb, exp_strb);
        check({tag, "_wdata"}, bus.req_wdata, exp_wdata);
        for (int i = 0; i < ready_delay; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, bus.req_valid, 1);
            check({tag, "_hold_addr"}, bus.req_addr, exp_addr);
            check({tag, "_hold_wdata"}, bus.req_wdata, exp_wdata);
            check({tag, "_hold_stall"}, mem_stall, 1);
            check({tag, "_hold_no_wb"}, wb_valid, 0);
        end
        bus.req_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_ready = 1'b0;
        check({tag, "_req_dropped"}, bus.req_valid, 0);
        check({tag, "_wb_valid"}, wb_valid, 1);
        check({tag, "_wb_wen"}, wb_wen, 0);
        check({tag, "_stall_done"}, mem_stall, 0);
    endtask

    initial begin
        bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_rdata = '0;

        repeat (2) @(posedge clk); #1;
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_misalign", misalign, 0);
        @(negedge clk); reset = 1'b1;

        // ALU passthrough, back-to-back, second one to x0
        send(1'b0, 1'b0, 64'h1234, 2'd0, 1'b0, 6'd5, 64'h0);
        check("alu_wb_valid", wb_valid, 1);
        check("alu_wb_wen", wb_wen, 1);
        check("alu_wb_data", wb_data, 64'h1234);
        check("alu_wb_dest", wb_dest_reg, 5);
        check("alu_stall", mem_stall, 0);
        check("alu_no_req", bus.req_valid, 0);
        send(1'b0, 1'b0, 64'hBEEF, 2'd0, 1'b0, 6'd0, 64'h0);
        check("alu0_wb_valid", wb_valid, 1);
        check("alu0_wb_wen", wb_wen, 0);
        check("alu0_wb_data", wb_data, 64'hBEEF);
        @(posedge clk); #1;
        check("alu_pulse", wb_valid, 0);

        do_load("lb",  64'h1003, 2'd0, 1'b0, 6'd7, 64'h00000000_80000000, 64'h1000, 64'hFFFFFFFF_FFFFFF80, 1'b1);
        do_load("lbu", 64'h1003, 2'd0, 1'b1, 6'd7, 64'h00000000_80000000, 64'h1000, 64'h80, 1'b1);
        do_load("lw",  64'h3004, 2'd2, 1'b0, 6'd9, 64'h87654321_00000000, 64'h3000, 64'hFFFFFFFF_87654321, 1'b1);
        do_load("lh",  64'h3002, 2'd1, 1'b0, 6'd9, 64'h00000000_7FFF0000, 64'h3000, 64'h7FFF, 1'b1);
        do_load("ld",  64'h3008, 2'd3, 1'b1, 6'd9, 64'hDEADBEEF_CAFEF00D, 64'h3008, 64'hDEADBEEF_CAFEF00D, 1'b1);
        do_load("ld0", 64'h3010, 2'd3, 1'b0, 6'd0, 64'h11112222_33334444, 64'h3010, 64'h11112222_33334444, 1'b0);

        do_store("sh", 64'h2006, 2'd1, 64'hABCD, 64'h2000, 8'hC0, 64'hABCDABCD_ABCDABCD, 3);
        do_store("sw", 64'h4004, 2'd2, 64'h11223344_55667788, 64'h4000, 8'hF0, 64'h55667788_55667788, 0);
        do_store("sb", 64'h4001, 2'd0, 64'hAA, 64'h4000, 8'h02, 64'hAAAAAAAA_AAAAAAAA, 1);

        // Misaligned accesses never reach the bus
        send(1'b1, 1'b1, 64'h1002, 2'd2, 1'b0, 6'd4, 64'h0);
        check("mis_lw_no_req", bus.req_valid, 0);
        check("mis_lw_flag", misalign, 1);
        check("mis_lw_wb_valid", wb_valid, 1);
        check("mis_lw_wb_wen", wb_wen, 0);
        check("mis_lw_stall", mem_stall, 0);
        @(posedge clk); #1;
        check("mis_lw_pulse", misalign, 0);
        send(1'b1, 1'b0, 64'h2001, 2'd1, 1'b0, 6'd4, 64'h55);
        check("mis_sh_no_req", bus.req_valid, 0);
        check("mis_sh_flag", misalign, 1);

        // Reset while waiting for a load response, then a stale response
        send(1'b1, 1'b1, 64'h5000, 2'd3, 1'b0, 6'd8, 64'h0);
        bus.req_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_ready = 1'b0;
        check("rw_in_wait", mem_stall, 1);
        #2 reset = 1'b0;
        #1;
        check("rw_req_valid", bus.req_valid, 0);
        check("rw_wb_valid", wb_valid, 0);
        check("rw_stall", mem_stall, 0);
        @(negedge clk); reset = 1'b1;
        bus.resp_valid = 1'b1; bus.resp_rdata = 64'h12345678;
        @(posedge clk); #1;
        bus.resp_valid = 1'b0;
        check("rw_stale_wb", wb_valid, 0);
        check("rw_stale_stall", mem_stall, 0);
        @(posedge clk); #1;
        check("rw_stale_wb2", wb_valid, 0);

        // Reset while a request is pending drops req_valid immediately
        send(1'b1, 1'b0, 64'h6000, 2'd3, 1'b0, 6'd2, 64'h99);
        check("rr_req_valid", bus.req_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("rr_req_dropped", bus.req_valid, 0);
        check("rr_stall", mem_stall, 0);
        @(negedge clk); reset = 1'b1;
        bus.req_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_ready = 1'b0;
        check("rr_no_wb", wb_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0x0 exp=0x1");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes the ALU result, destination register, memory-active and load flags, and the EX/MEM valid handshake.
- Performs data-memory loads and stores over a valid/ready request bus with a separate response channel.
- Presents registered results to write-back.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- ADDR_W, 64, data-address width.
- DATA_W, 64, data-bus width; fixed at 64, with 8 byte lanes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX/MEM result valid; connects to the execute stage's EXMEM_ready.
- ex_aluresult  in  64  ALU result; for memory ops, the effective address.
- ex_dest_reg  in  6  destination register index.
- ex_mem_active  in  1  operation accesses memory.
- ex_load  in  1  1 = load, 0 = store (meaningful only when ex_mem_active).
- ex_store_data  in  64  store source (rs2 value).
- ex_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- ex_unsigned  in  1  zero-extend the load result.
- mem_stall  out  1  upstream must hold ex_* stable.
- req_valid  out  1  memory request valid.
- req_ready  in  1  memory accepts the request.
- req_addr  out  64  address, aligned down to 8 bytes.
- req_we  out  1  write enable.
- req_wstrb  out  8  byte-lane strobes.
- req_wdata  out  64  lane-replicated store data.
- resp_valid  in  1  load response valid.
- resp_rdata  in  64  load response data (full 8-byte line).
- wb_valid  out  1  one-cycle pulse: result ready for write-back.
- wb_wen  out  1  register write enable.
- wb_dest_reg  out  6  write-back register index.
- wb_data  out  64  write-back data.
- misalign  out  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0; in particular req_valid drops immediately.
  - Captured registers are cleared.
- FSM states: IDLE, REQ, WAIT.
- mem_stall = (state != IDLE), combinational.
- IDLE, on ex_valid = 1, ex_* is captured at the clock edge:
  - Non-memory op:
    - Next cycle: wb_valid = 1, wb_data = ex_aluresult, wb_dest_reg = ex_dest_reg.
    - wb_wen = (ex_dest_reg != 0).
    - State stays IDLE; latency is 1 cycle, back-to-back ops are allowed.
  - Memory op, misaligned (address not a multiple of 1 << size):
    - No bus request is issued.
    - Next cycle: wb_valid = 1, wb_wen = 0, misalign = 1.
    - State stays IDLE.
  - Memory op, aligned:
    - Next state is REQ; req_valid = 1 registered.
    - req_addr = {addr[63:3], 3'b000}.
    - req_we = !ex_load.
- REQ:
  - req_* are held stable until req_ready = 1 (valid/ready transfer on the same edge).
  - On transfer of a store: req_valid is cleared; next cycle wb_valid = 1 with wb_wen = 0; state goes to IDLE.
  - On transfer of a load: req_valid is cleared; state goes to WAIT.
- WAIT:
  - On resp_valid = 1: next cycle wb_valid = 1, wb_wen = (dest != 0), wb_data = aligned and extended load data; state goes to IDLE.
  - resp_valid seen in IDLE or REQ is ignored; this covers stale responses after a reset.
- Load alignment:
  - Lane = addr[2:0].
  - The selected byte, half or word is taken from resp_rdata[8*lane +: 8 << size].
  - Result is sign-extended from its MSB, or zero-extended when ex_unsigned = 1.
  - Double returns the full word; ex_unsigned is ignored for double.
- Store strobes and data:
  - req_wstrb = ((1 << (1 << size)) - 1) << addr[2:0].
  - req_wdata = low (8 << size) bits of store data, replicated to fill 64 bits.
- The next instruction is accepted no earlier than the cycle after the state returns to IDLE.
- Register index 0 is never written: wb_wen = 0 whenever wb_dest_reg = 0.
- Reset asserted in REQ or WAIT aborts the transaction; no wb_valid is produced.

Decomposition:
- Package mem_stage_pkg holds:
  - enum mem_size_e {SZ_B, SZ_H, SZ_W, SZ_D}.
  - enum mem_state_e {IDLE, REQ, WAIT}.
  - Constant LANES = 8.
- Sub-module load_align (combinational): inputs rdata, lane, size, unsigned; output wb_data.
- Strobe and replication logic stays inline.

Test Plan:
- ALU passthrough: ex_valid with mem_active = 0, aluresult = 0x1234, dest = 5 -> next cycle wb_valid = 1, wb_wen = 1, wb_data = 0x1234, mem_stall never asserted.
- Signed byte load:
  - Stimulus: addr 0x1003, size = 0, unsigned = 0, resp_rdata = 0x00000000_80000000.
  - Required: req_addr = 0x1000, wb_data = 0xFFFFFFFF_FFFFFF80.
  - Repeat with unsigned = 1 -> wb_data = 0x80.
- Half store: addr 0x2006, store_data = 0xABCD -> req_we = 1, req_wstrb = 0xC0, req_wdata = 0xABCDABCD_ABCDABCD, wb_wen = 0.
- Backpressure: req_ready held low for 3 cycles in REQ -> req_valid and req_addr stable, mem_stall = 1 throughout; transfer on the 4th cycle.
- Misaligned word load: addr 0x1002, size = 2 -> no req_valid, misalign pulse, wb_valid with wb_wen = 0.
- Reset in WAIT:
  - Stimulus: assert reset mid-cycle, then send a late resp_valid after release.
  - Required: req_valid, wb_valid and mem_stall are 0 immediately; the late response produces no wb_valid.
  - Also: load to dest 0 -> wb_wen = 0.
